load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 47 ++++
 rtl/load_store_unit_load_extend.sv | 27 ++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] wd;
    case (size)
      SZ_BYTE: wd = {4{wdata[7:0]}};
      SZ_HALF: wd = {2{wdata[15:0]}};
      SZ_WORD: wd = wdata;
      default: wd = 32'd0;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed lane of a read word and sign/zero-extends it to 32 bits.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [31:0] lane_s;

  assign lane_s = rdata_i >> {off_i, 3'b000};

  // Extend the selected lane according to access size
  always_comb begin
    data_o = 32'd0;
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & lane_s[7]}}, lane_s[7:0]};
      SZ_HALF: data_o = {{16{signed_i & lane_s[15]}}, lane_s[15:0]};
      SZ_WORD: data_o = rdata_i;
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: captures a CPU request, issues one memory
// access with a bounded wait for ack, and returns a one-cycle response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        ready_q;
  logic        stall_q;
  logic        en_q;
  logic        we_q;
  logic        rvalid_q;
  logic [31:0] ext_s;

  load_extend u_extend (
    .rdata_i  (mem_rdata),
    .off_i    (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext_s)
  );

  // Request FSM; every output is a flop updated alongside the state
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      cnt_q    <= 8'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      stall_q  <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= replicate(req_size, req_wdata);
            be_q     <= byte_mask(req_size, req_addr[1:0]);
            cnt_q    <= 8'd0;
            ready_q  <= 1'b0;
            stall_q  <= 1'b1;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
            end else begin
              state_q <= ACCESS;
              en_q    <= 1'b1;
              we_q    <= req_write;
            end
          end
        end
        ACCESS: begin
          // An ack in the final allowed cycle still completes normally
          if (mem_ack) begin
            state_q  <= RESP;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= write_q ? 32'd0 : ext_s;
            err_q    <= 1'b0;
          end else if (cnt_q == TO_LAST) begin
            state_q  <= RESP;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= 32'd0;
            err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          rdata_q  <= 32'd0;
          err_q    <= 1'b0;
          stall_q  <= 1'b0;
          ready_q  <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          en_q     <= 1'b0;
          we_q     <= 1'b0;
          rvalid_q <= 1'b0;
          rdata_q  <= 32'd0;
          err_q    <= 1'b0;
          stall_q  <= 1'b0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign stall      = stall_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_en     = en_q;
  assign mem_we     = we_q;
  assign mem_be     = be_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a behavioural access model.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .clr_n(clr_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic over the access rules
  function automatic bit m_bad(input int sz, input logic [31:0] a);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] m_be(input int sz, input logic [31:0] a);
    int off = int'(a % 4);
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input int sz, input logic [31:0] wd);
    if (sz == 0) return 32'(wd % 256) * 32'h0101_0101;
    if (sz == 1) return 32'(wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rd(input int sz, input bit sg, input logic [31:0] a, input logic [31:0] rd);
    longint v, bits;
    v = longint'(rd / (32'd1 << (8 * (a % 4))));
    bits = (sz == 0) ? 8 : (sz == 1) ? 16 : 32;
    v = v % (64'sd1 <<< bits);
    if (sg && bits < 32 && v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
    return 32'(v);
  endfunction

  // Issue one request; ackat = ACCESS cycle index carrying the ack (>= TMO: never)
  task automatic run(input bit wr, input int sz, input bit sg, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int ackat);
    bit done;
    bit exp_err;
    check("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = 2'(sz); req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    if (m_bad(sz, a)) begin
      check("bad_valid", {31'd0, resp_valid}, 32'd1);
      check("bad_err", {31'd0, resp_err}, 32'd1);
      check("bad_no_en", {31'd0, mem_en}, 32'd0);
      check("bad_rdata", resp_rdata, 32'd0);
    end else begin
      done = 1'b0;
      for (int k = 0; k < TMO && !done; k++) begin
        check("acc_en", {31'd0, mem_en}, 32'd1);
        check("acc_we", {31'd0, mem_we}, {31'd0, wr});
        check("acc_be", {28'd0, mem_be}, {28'd0, m_be(sz, a)});
        check("acc_addr", mem_addr, a - (a % 4));
        if (wr) check("acc_wdata", mem_wdata, m_wd(sz, wd));
        check("acc_stall", {31'd0, stall}, 32'd1);
        check("acc_rvalid", {31'd0, resp_valid}, 32'd0);
        mem_ack = (k == ackat);
        mem_rdata = rd;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (k == ackat) done = 1'b1;
      end
      exp_err = (ackat >= TMO);
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      check("resp_rdata", resp_rdata, (exp_err || wr) ? 32'd0 : m_rd(sz, sg, a, rd));
      check("resp_no_en", {31'd0, mem_en}, 32'd0);
      check("resp_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    check("post_valid", {31'd0, resp_valid}, 32'd0);
    check("post_rdata", resp_rdata, 32'd0);
    check("post_ready", {31'd0, req_ready}, 32'd1);
    check("post_stall", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    clr_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_en", {31'd0, mem_en}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    clr_n = 1'b1;
    @(posedge clk); #1;

    run(1'b0, 0, 1'b1, 32'h0000_0003, 32'd0, 32'h80FF_1234, 0);
    run(1'b0, 1, 1'b0, 32'h0000_0006, 32'd0, 32'hBEEF_0000, 0);
    run(1'b1, 0, 1'b0, 32'h0000_0011, 32'h0000_00AB, 32'd0, 1);
    run(1'b1, 2, 1'b0, 32'h0000_0002, 32'h1234_5678, 32'd0, 0);
    run(1'b0, 2, 1'b0, 32'h0000_0040, 32'd0, 32'hCAFE_F00D, 99);
    run(1'b0, 2, 1'b0, 32'h0000_0040, 32'd0, 32'hCAFE_F00D, TMO - 1);
    run(1'b0, 3, 1'b0, 32'h0000_0000, 32'd0, 32'd0, 0);
    run(1'b0, 1, 1'b1, 32'h0000_0001, 32'd0, 32'd0, 0);

    // ack while idle must not produce a response
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_ack_valid", {31'd0, resp_valid}, 32'd0);
      check("idle_ack_ready", {31'd0, req_ready}, 32'd1);
    end
    mem_ack = 1'b0;

    // reset mid-ACCESS abandons the transaction
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_en", {31'd0, mem_en}, 32'd1);
    @(posedge clk); #1;
    clr_n = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b1;
    check("mid_rst_en", {31'd0, mem_en}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    repeat (TMO + 2) begin
      check("mid_rst_novalid", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int sz;
      a = $urandom;
      sz = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) a[0] = 1'b0;
        if (sz == 2) a[1:0] = 2'b00;
      end
      run(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, TMO + 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
